// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC sequencer: one shared add/sub, three phases (X, Y, Z) per micro-rotation.
// Optional vectoring mode (mode port) is enabled by defining CORDIC_VECTORING_EN.
module cordic_iter_ctrl #(
  parameter int BITS  = 16,
  parameter int ITERS = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] x_in,
  input  logic [BITS-1:0] y_in,
  input  logic [BITS-1:0] z_in,
`ifdef CORDIC_VECTORING_EN
  input  logic            mode,
`endif
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] x_out,
  output logic [BITS-1:0] y_out,
  output logic [BITS-1:0] z_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PH_X,
    S_PH_Y,
    S_PH_Z,
    S_DONE
  } state_t;

  state_t          state, nstate;
  logic [BITS-1:0] x, y, z, xt;
  logic [3:0]      i;
  logic            d, d_now;
  logic            accept, last;
  logic [BITS-1:0] x_sh, y_sh;
  logic [BITS-1:0] add_a, add_b, sum;
  logic            sub;
  logic [15:0]     atan16;
  logic [BITS-1:0] atan_i;
`ifdef CORDIC_VECTORING_EN
  logic            mode_r;
`endif

  // atan(2^-i) with pi = 0x8000
  function automatic logic [15:0] atan_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_rom = 16'h2000;
      4'd1:    atan_rom = 16'h12E4;
      4'd2:    atan_rom = 16'h09FB;
      4'd3:    atan_rom = 16'h0511;
      4'd4:    atan_rom = 16'h028B;
      4'd5:    atan_rom = 16'h0146;
      4'd6:    atan_rom = 16'h00A3;
      4'd7:    atan_rom = 16'h0051;
      4'd8:    atan_rom = 16'h0029;
      4'd9:    atan_rom = 16'h0014;
      4'd10:   atan_rom = 16'h000A;
      4'd11:   atan_rom = 16'h0005;
      4'd12:   atan_rom = 16'h0003;
      4'd13:   atan_rom = 16'h0001;
      4'd14:   atan_rom = 16'h0001;
      default: atan_rom = 16'h0000;
    endcase
  endfunction

  always_comb begin
    atan16 = atan_rom(i);
    // top BITS bits == entry >>> (16-BITS) for the narrower datapaths
    atan_i = atan16[15 -: BITS];
    x_sh   = $signed(x) >>> i;
    y_sh   = $signed(y) >>> i;
    accept = start && ((state == S_IDLE) || (state == S_DONE));
    last   = (i == 4'(ITERS - 1));
  end

  always_comb begin
`ifdef CORDIC_VECTORING_EN
    d_now = mode_r ? y[BITS-1] : ~z[BITS-1];
`else
    d_now = ~z[BITS-1];
`endif
  end

  always_comb begin
    sum = sub ? (add_a - add_b) : (add_a + add_b);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  // Operand routing for the single shared adder follows the phase.
  always_comb begin
    nstate = state;
    busy   = 1'b0;
    done   = 1'b0;
    add_a  = x;
    add_b  = y_sh;
    sub    = d_now;
    unique case (state)
      S_IDLE: if (start) nstate = S_PH_X;
      S_PH_X: begin
        busy   = 1'b1;
        nstate = S_PH_Y;
      end
      S_PH_Y: begin
        busy   = 1'b1;
        add_a  = y;
        add_b  = x_sh;
        sub    = ~d;
        nstate = S_PH_Z;
      end
      S_PH_Z: begin
        busy   = 1'b1;
        add_a  = z;
        add_b  = atan_i;
        sub    = d;
        nstate = last ? S_DONE : S_PH_X;
      end
      S_DONE: begin
        done   = 1'b1;
        nstate = start ? S_PH_X : S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x     <= '0;
      y     <= '0;
      z     <= '0;
      xt    <= '0;
      i     <= '0;
      d     <= 1'b0;
      x_out <= '0;
      y_out <= '0;
      z_out <= '0;
`ifdef CORDIC_VECTORING_EN
      mode_r <= 1'b0;
`endif
    end else begin
      if (accept) begin
        x <= x_in;
        y <= y_in;
        z <= z_in;
        i <= '0;
`ifdef CORDIC_VECTORING_EN
        mode_r <= mode;
`endif
      end
      unique case (state)
        S_PH_X: begin
          d  <= d_now;
          xt <= sum;
        end
        S_PH_Y: begin
          y <= sum;
          x <= xt;
        end
        S_PH_Z: begin
          z <= sum;
          i <= i + 4'd1;
          // x/y are final after the last PH_Y; z is final in this adder result
          if (last) begin
            x_out <= x;
            y_out <= y;
            z_out <= sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
